mgt_reset_sequencer: RTL and testbench

Parametrised multi-link successor to the fixed single-link MGT control block: it sequences PLL reset, MGT reset and link-ready for `NUM_MGTS` transceivers sharing one QPLL. It adds lock/startup timeouts, bounded automatic retry, a sticky failure flag and per-channel re-reset without disturbing neighbouring links. It sits between the ipbus control registers and the MGT wrapper in the trigger link path, and is triplicated by its own `_tmr` wrapper.

---
 rtl/mgt_seq_pkg.sv | 33 +++
 rtl/mgt_reset_sequencer_if.sv | 30 +++
 rtl/mgt_channel_fsm.sv | 55 +++++
 rtl/mgt_reset_sequencer.sv | 111 +++++++++++
 tb/tb_mgt_reset_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mgt_seq_pkg.sv
// Shared encodings for the MGT reset sequencer: top/channel FSM states,
// status field width and the counter-width helper.
package mgt_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    TOP_PLL_RST  = 3'd0,
    TOP_PLL_WAIT = 3'd1,
    TOP_MGT_RST  = 3'd2,
    TOP_MGT_WAIT = 3'd3,
    TOP_SETTLE   = 3'd4,
    TOP_READY    = 3'd5,
    TOP_FAILED   = 3'd6
  } top_state_t;

  typedef enum logic [1:0] {
    CH_RST  = 2'd0,
    CH_WAIT = 2'd1,
    CH_UP   = 2'd2
  } ch_state_t;

  // Width needed to hold the largest of four cycle counts.
  function automatic int cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mgt_reset_sequencer_if.sv
// Status/control bundle between the ipbus register block (master) and the
// reset sequencer (slave).
interface mgt_reset_sequencer_if
  import mgt_seq_pkg::*;
#(
  parameter int NUM_MGTS = 4
);
  logic                pll_lock_i;
  logic [NUM_MGTS-1:0] mgt_startup_done_i;
  logic                ext_pll_reset_i;
  logic [NUM_MGTS-1:0] ext_mgt_reset_i;
  logic                force_not_ready;
  logic                pll_reset_o;
  logic [NUM_MGTS-1:0] mgt_reset_o;
  logic [NUM_MGTS-1:0] ready_o;
  logic                all_ready_o;
  logic [7:0]          retry_cnt_o;
  logic                failed_o;
  logic [STATE_W-1:0]  state_o;

  modport master (
    output pll_lock_i, mgt_startup_done_i, ext_pll_reset_i, ext_mgt_reset_i, force_not_ready,
    input  pll_reset_o, mgt_reset_o, ready_o, all_ready_o, retry_cnt_o, failed_o, state_o
  );

  modport slave (
    input  pll_lock_i, mgt_startup_done_i, ext_pll_reset_i, ext_mgt_reset_i, force_not_ready,
    output pll_reset_o, mgt_reset_o, ready_o, all_ready_o, retry_cnt_o, failed_o, state_o
  );
endinterface

// File: rtl/mgt_channel_fsm.sv
// Per-channel re-reset FSM: parks in CH_UP while disabled, otherwise pulses
// its own MGT reset on request or after a startup-done timeout.
module mgt_channel_fsm
  import mgt_seq_pkg::*;
#(
  parameter int MGT_RESET_CYCLES = 16,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ext_reset,
  input  logic startup_done,
  output logic mgt_reset,
  output logic up
);
  localparam int CW = cnt_w(MGT_RESET_CYCLES, TIMEOUT_CYCLES, 1, 1);

  ch_state_t     state, nxt;
  logic [CW-1:0] cnt;
  logic          clr;

  always_comb begin
    nxt = state;
    clr = 1'b0;
    if (ext_reset) begin
      nxt = CH_RST;
      clr = 1'b1;
    end else begin
      case (state)
        CH_RST:  if (cnt == CW'(MGT_RESET_CYCLES - 1)) nxt = CH_WAIT;
        CH_WAIT: begin
          if (startup_done) nxt = CH_UP;
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) nxt = CH_RST;
        end
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state     <= CH_UP;
      cnt       <= '0;
      mgt_reset <= 1'b0;
      up        <= 1'b1;
    end else begin
      state     <= nxt;
      cnt       <= (clr || nxt != state) ? '0 : cnt + 1'b1;
      mgt_reset <= nxt == CH_RST;
      up        <= nxt == CH_UP;
    end
  end

endmodule

// File: rtl/mgt_reset_sequencer.sv
// Shared-QPLL reset sequencer for NUM_MGTS links: PLL reset, MGT reset,
// settle, ready, with bounded retry, sticky failure and per-channel re-reset.
module mgt_reset_sequencer
  import mgt_seq_pkg::*;
#(
  parameter int NUM_MGTS         = 4,
  parameter int PLL_RESET_CYCLES = 16,
  parameter int MGT_RESET_CYCLES = 16,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int SETTLE_CYCLES    = 256,
  parameter int ALLOW_RETRY      = 1,
  parameter int MAX_RETRIES      = 7
) (
  input  logic                  clock_40,
  input  logic                  reset_i,
  mgt_reset_sequencer_if.slave  bus
);
  localparam int CW = cnt_w(PLL_RESET_CYCLES, MGT_RESET_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES);

  top_state_t          state, nxt;
  logic [CW-1:0]       cnt;
  logic [7:0]          retry_cnt;
  logic                pll_rst_q, all_rst_q, failed_q;
  logic                clr, retry, all_done, in_ready;
  logic [NUM_MGTS-1:0] ch_rst, ch_up, ch_ext;

  assign all_done = &bus.mgt_startup_done_i;
  assign in_ready = state == TOP_READY;

  always_comb begin
    nxt   = state;
    clr   = 1'b0;
    retry = 1'b0;
    if (bus.ext_pll_reset_i) begin
      nxt = TOP_PLL_RST;
      clr = 1'b1;
    end else begin
      case (state)
        TOP_PLL_RST:  if (cnt == CW'(PLL_RESET_CYCLES - 1)) nxt = TOP_PLL_WAIT;
        TOP_PLL_WAIT: begin
          if (bus.pll_lock_i) nxt = TOP_MGT_RST;
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) retry = 1'b1;
        end
        TOP_MGT_RST:  if (cnt == CW'(MGT_RESET_CYCLES - 1)) nxt = TOP_MGT_WAIT;
        TOP_MGT_WAIT: begin
          if (all_done) nxt = TOP_SETTLE;
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) retry = 1'b1;
        end
        TOP_SETTLE: begin
          if (!all_done) nxt = TOP_MGT_WAIT;
          else if (cnt == CW'(SETTLE_CYCLES - 1)) nxt = TOP_READY;
        end
        // Lock loss restarts without consuming a retry.
        TOP_READY:  if (!bus.pll_lock_i) nxt = TOP_PLL_RST;
        TOP_FAILED: nxt = TOP_FAILED;
        default:    nxt = TOP_PLL_RST;
      endcase
      if (retry)
        nxt = (ALLOW_RETRY != 0 && retry_cnt < 8'(MAX_RETRIES)) ? TOP_PLL_RST : TOP_FAILED;
    end
  end

  always_ff @(posedge clock_40) begin
    if (reset_i) begin
      state     <= TOP_PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst_q <= 1'b1;
      all_rst_q <= 1'b1;
      failed_q  <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (clr || nxt != state) ? '0 : cnt + 1'b1;
      if (bus.ext_pll_reset_i)
        retry_cnt <= '0;
      else if (retry && nxt == TOP_PLL_RST && retry_cnt != 8'hff)
        retry_cnt <= retry_cnt + 8'd1;
      pll_rst_q <= nxt == TOP_PLL_RST;
      all_rst_q <= nxt != TOP_READY;
      failed_q  <= nxt == TOP_FAILED;
    end
  end

  // Full restart and lock loss outrank a channel re-reset on the same cycle.
  assign ch_ext = bus.ext_mgt_reset_i & {NUM_MGTS{~bus.ext_pll_reset_i & bus.pll_lock_i}};

  for (genvar k = 0; k < NUM_MGTS; k++) begin : g_ch
    mgt_channel_fsm #(
      .MGT_RESET_CYCLES (MGT_RESET_CYCLES),
      .TIMEOUT_CYCLES   (TIMEOUT_CYCLES)
    ) u_ch (
      .clk          (clock_40),
      .rst          (reset_i),
      .enable       (in_ready),
      .ext_reset    (ch_ext[k]),
      .startup_done (bus.mgt_startup_done_i[k]),
      .mgt_reset    (ch_rst[k]),
      .up           (ch_up[k])
    );
  end

  assign bus.pll_reset_o = pll_rst_q;
  assign bus.mgt_reset_o = {NUM_MGTS{all_rst_q}} | ch_rst;
  assign bus.ready_o     = ch_up & bus.mgt_startup_done_i &
                           {NUM_MGTS{in_ready & bus.pll_lock_i & ~bus.force_not_ready}};
  assign bus.all_ready_o = &bus.ready_o;
  assign bus.retry_cnt_o = retry_cnt;
  assign bus.failed_o    = failed_q;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_mgt_reset_sequencer.sv
// Directed bench: stimulus queues expected (cycle, output, value) entries and
// a negedge monitor compares the DUT outputs when each entry's cycle arrives.
module tb_mgt_reset_sequencer;
  import mgt_seq_pkg::*;

  localparam int N = 4;
  localparam int SEL_STATE = 0, SEL_PLL = 1, SEL_MGT = 2, SEL_RDY = 3,
                 SEL_ALL = 4, SEL_RETRY = 5, SEL_FAILED = 6;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic clock_40 = 1'b0;
  logic reset_i  = 1'b1;
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  mgt_reset_sequencer_if #(.NUM_MGTS(N)) bus ();

  mgt_reset_sequencer #(
    .NUM_MGTS(N), .PLL_RESET_CYCLES(16), .MGT_RESET_CYCLES(16), .TIMEOUT_CYCLES(64),
    .SETTLE_CYCLES(256), .ALLOW_RETRY(1), .MAX_RETRIES(2)
  ) dut (
    .clock_40 (clock_40),
    .reset_i  (reset_i),
    .bus      (bus)
  );

  always #5 clock_40 = ~clock_40;
  always @(posedge clock_40) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SEL_STATE:  return 32'(bus.state_o);
      SEL_PLL:    return 32'(bus.pll_reset_o);
      SEL_MGT:    return 32'(bus.mgt_reset_o);
      SEL_RDY:    return 32'(bus.ready_o);
      SEL_ALL:    return 32'(bus.all_ready_o);
      SEL_RETRY:  return 32'(bus.retry_cnt_o);
      SEL_FAILED: return 32'(bus.failed_o);
      default:    return 32'hffff_ffff;
    endcase
  endfunction

  always @(negedge clock_40) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] act;
        act = sample(sb[i].sel);
        n_chk++;
        if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %0h, expected %0h", sb[i].nm, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: check for cyc %0d never sampled", sb[i].nm, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock_40);
    #1;
  endtask

  task automatic expect_at(input int dc, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dc;
    e.sel = sel;
    e.val = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  initial begin
    bus.pll_lock_i         = 1'b1;
    bus.mgt_startup_done_i = '1;
    bus.ext_pll_reset_i    = 1'b0;
    bus.ext_mgt_reset_i    = '0;
    bus.force_not_ready    = 1'b0;

    // Reset values while reset_i is high.
    step(3);
    expect_at(0, SEL_STATE, 0, "rst_state");
    expect_at(0, SEL_PLL, 1, "rst_pll");
    expect_at(0, SEL_MGT, 4'hf, "rst_mgt");
    expect_at(0, SEL_RDY, 0, "rst_ready");
    expect_at(0, SEL_ALL, 0, "rst_all");
    expect_at(0, SEL_RETRY, 0, "rst_retry");
    expect_at(0, SEL_FAILED, 0, "rst_failed");

    // Release: pll_reset 16 cycles, all_ready after exactly 290.
    step(1);
    reset_i = 1'b0;
    expect_at(0, SEL_PLL, 1, "pll_first");
    expect_at(0, SEL_STATE, 0, "state_first");
    expect_at(15, SEL_PLL, 1, "pll_last");
    expect_at(16, SEL_PLL, 0, "pll_off");
    expect_at(16, SEL_STATE, 1, "pll_wait");
    expect_at(289, SEL_ALL, 0, "all_ready_early");
    expect_at(289, SEL_STATE, 4, "settle");
    expect_at(290, SEL_ALL, 1, "all_ready_290");
    expect_at(290, SEL_RDY, 4'hf, "ready_290");
    expect_at(290, SEL_STATE, 5, "ready_state");
    step(295);

    // Per-channel re-reset of link 2 only.
    bus.ext_mgt_reset_i = 4'b0100;
    expect_at(0, SEL_MGT, 0, "ch_mgt_pre");
    expect_at(1, SEL_MGT, 4'b0100, "ch_mgt_on");
    expect_at(1, SEL_RDY, 4'b1011, "ch_ready_drop");
    expect_at(16, SEL_MGT, 4'b0100, "ch_mgt_last");
    expect_at(17, SEL_MGT, 0, "ch_mgt_off");
    expect_at(20, SEL_RDY, 4'b1011, "ch_ready_wait");
    expect_at(21, SEL_RDY, 4'hf, "ch_ready_back");
    expect_at(21, SEL_STATE, 5, "ch_top_ready");
    step(1);
    bus.ext_mgt_reset_i    = '0;
    bus.mgt_startup_done_i = 4'b1011;
    step(19);
    bus.mgt_startup_done_i = 4'hf;
    step(10);

    // force_not_ready masks ready in the same cycle.
    bus.force_not_ready = 1'b1;
    expect_at(0, SEL_RDY, 0, "force_mask");
    expect_at(0, SEL_ALL, 0, "force_all");
    step(1);
    expect_at(0, SEL_STATE, 5, "force_stay");
    bus.force_not_ready = 1'b0;
    expect_at(0, SEL_RDY, 4'hf, "force_release");
    step(3);

    // One-cycle lock loss: restart without counting a retry.
    bus.pll_lock_i = 1'b0;
    expect_at(0, SEL_RDY, 0, "lock_loss_mask");
    expect_at(1, SEL_RDY, 0, "lock_loss_ready");
    expect_at(1, SEL_STATE, 0, "lock_loss_state");
    expect_at(1, SEL_RETRY, 0, "lock_loss_retry");
    expect_at(1, SEL_PLL, 1, "lock_loss_pll");
    step(1);
    bus.pll_lock_i = 1'b1;
    expect_at(289, SEL_STATE, 4, "relock_settle");
    expect_at(290, SEL_STATE, 5, "relock_ready");
    step(295);

    // Full restart and channel 0 re-reset together: restart wins.
    bus.ext_pll_reset_i = 1'b1;
    bus.ext_mgt_reset_i = 4'b0001;
    expect_at(1, SEL_STATE, 0, "both_state");
    expect_at(1, SEL_PLL, 1, "both_pll");
    expect_at(1, SEL_MGT, 4'hf, "both_mgt");
    expect_at(1, SEL_ALL, 0, "both_all");
    step(1);
    bus.ext_pll_reset_i = 1'b0;
    bus.ext_mgt_reset_i = '0;
    expect_at(289, SEL_ALL, 0, "both_all_early");
    expect_at(290, SEL_ALL, 1, "both_all_ready");
    expect_at(290, SEL_MGT, 0, "both_mgt_clear");
    step(295);

    // No lock: two retries then FAILED; restart clears flags.
    bus.pll_lock_i      = 1'b0;
    bus.ext_pll_reset_i = 1'b1;
    step(1);
    bus.ext_pll_reset_i = 1'b0;
    expect_at(0, SEL_STATE, 0, "to_start");
    expect_at(79, SEL_STATE, 1, "to1_wait");
    expect_at(79, SEL_RETRY, 0, "to1_retry_pre");
    expect_at(80, SEL_STATE, 0, "to1_restart");
    expect_at(80, SEL_RETRY, 1, "to1_retry");
    expect_at(160, SEL_RETRY, 2, "to2_retry");
    expect_at(239, SEL_STATE, 1, "to3_wait");
    expect_at(239, SEL_FAILED, 0, "to3_failed_pre");
    expect_at(240, SEL_STATE, 6, "failed_state");
    expect_at(240, SEL_FAILED, 1, "failed_flag");
    expect_at(240, SEL_RETRY, 2, "failed_retry");
    expect_at(240, SEL_PLL, 0, "failed_pll");
    expect_at(240, SEL_MGT, 4'hf, "failed_mgt");
    expect_at(248, SEL_STATE, 6, "failed_sticky");
    step(250);
    bus.ext_pll_reset_i = 1'b1;
    expect_at(1, SEL_STATE, 0, "clr_state");
    expect_at(1, SEL_FAILED, 0, "clr_failed");
    expect_at(1, SEL_RETRY, 0, "clr_retry");
    expect_at(1, SEL_PLL, 1, "clr_pll");
    step(1);
    bus.ext_pll_reset_i = 1'b0;

    for (int i = 0; i < 400 && sb.size() != 0; i++) step(1);
    if (sb.size() != 0) begin
      n_fail += sb.size();
      $display("FAIL drain: %0d checks still pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
